// File: rtl/bit_serializer_if.sv
// Handshake and serial-output bundle for bit_serializer.
//   din        parallel word offered by the producer
//   din_valid  din holds a valid word
//   din_ready  serializer can take a word this cycle
//   x          serial bit to the sequence detector
//   x_valid    x carries a data bit this cycle
//   last       x is the final bit of the current word
//   busy       shifter active or holding register full
// master: the word producer side; slave: the serializer itself.
interface bit_serializer_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             x;
    logic             x_valid;
    logic             last;
    logic             busy;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  x,
        input  x_valid,
        input  last,
        input  busy
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output x,
        output x_valid,
        output last,
        output busy
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the overlapping sequence detector.
// Words arrive on a valid/ready handshake and leave one bit per clock on x.
// A single holding register behind the shifter lets back-to-back words
// stream out with no idle cycles between them.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset, clears all state
//   bus      bit_serializer_if slave: din/din_valid/din_ready in,
//            x/x_valid/last/busy out
module bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic           clk,
    input  logic           reset_n,
    bit_serializer_if.slave bus
);
    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic {
        StIdle,
        StShift
    } state_e;

    state_e           state_q, state_d;
    logic             hold_full_q, hold_full_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] shift_next;
    logic             accept;
    logic             on_last;

    // Ready depends on state only, so there is no comb path from din_valid.
    assign accept  = bus.din_valid & ~hold_full_q;
    assign on_last = (state_q == StShift) && (cnt_q == CntLast);

    always_comb begin
        shift_next = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d     = state_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        hold_d      = hold_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shift_d = bus.din;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                shift_d = shift_next;
                cnt_d   = cnt_q + 1'b1;
                if (on_last) begin
                    cnt_d = '0;
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        // Bypass straight into the shifter to keep the stream gapless.
                        shift_d = bus.din;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (accept) begin
                    hold_d      = bus.din;
                    hold_full_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
        end
    end

    // Outputs come from registers only; x is forced low while idle so the
    // detector sees zeros between words.
    assign bus.x         = (state_q == StShift) & (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]);
    assign bus.x_valid   = (state_q == StShift);
    assign bus.last      = on_last;
    assign bus.busy      = (state_q == StShift) | hold_full_q;
    assign bus.din_ready = ~hold_full_q;
endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;
    localparam int unsigned WIDTH = 8;

    typedef struct packed {
        logic b;
        logic l;
    } exp_t;

    logic clk;
    logic reset_n;
    logic [WIDTH-1:0] din;
    logic din_valid;

    int tests = 0;
    int fails = 0;

    exp_t q_m[$];
    exp_t q_l[$];

    bit_serializer_if #(.WIDTH(WIDTH)) bus_m ();
    bit_serializer_if #(.WIDTH(WIDTH)) bus_l ();

    assign bus_m.din       = din;
    assign bus_m.din_valid = din_valid;
    assign bus_l.din       = din;
    assign bus_l.din_valid = din_valid;

    bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_msb (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus_m)
    );

    bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted word becomes WIDTH queued bits in wire order.
    task automatic push_word(input logic [WIDTH-1:0] w);
        for (int i = 0; i < WIDTH; i++) begin
            q_m.push_back('{b: w[WIDTH-1-i], l: (i == WIDTH - 1)});
            q_l.push_back('{b: w[i], l: (i == WIDTH - 1)});
        end
    endtask

    // With pending bits s (including the one on x now): stream is gapless,
    // a word is held exactly when s exceeds one word, busy whenever s > 0.
    task automatic mon_one(input string tag, input logic xv, input logic xb, input logic lst,
                           input logic rdy, input logic bsy, input int s, input exp_t e);
        check({tag, "_x_valid"}, xv, (s > 0));
        check({tag, "_busy"}, bsy, (s > 0));
        check({tag, "_din_ready"}, rdy, (s <= WIDTH));
        if (!rdy) check({tag, "_hold_while_idle"}, xv, 1);
        if (s > 0) begin
            check({tag, "_x"}, xb, e.b);
            check({tag, "_last"}, lst, e.l);
        end else begin
            check({tag, "_idle_x"}, xb, 0);
            check({tag, "_idle_last"}, lst, 0);
        end
    endtask

    always @(negedge clk) begin
        int   sm, sl;
        exp_t em, el;
        if (reset_n === 1'b1) begin
            sm = q_m.size();
            sl = q_l.size();
            em = '0;
            el = '0;
            if (sm > 0) em = q_m.pop_front();
            if (sl > 0) el = q_l.pop_front();
            mon_one("msb", bus_m.x_valid, bus_m.x, bus_m.last, bus_m.din_ready, bus_m.busy, sm, em);
            mon_one("lsb", bus_l.x_valid, bus_l.x, bus_l.last, bus_l.din_ready, bus_l.busy, sl, el);
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
        din = WIDTH'($urandom);
    endtask

    task automatic send(input logic [WIDTH-1:0] w);
        logic rdy;
        bit   done;
        done      = 0;
        din       = w;
        din_valid = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            rdy = bus_m.din_ready;
            @(posedge clk);
            if (rdy) begin
                push_word(w);
                done = 1;
            end
        end
        if (!done) check("send_timeout", 0, 1);
        #1;
        din_valid = 1'b0;
        din       = WIDTH'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_msb_x"}, bus_m.x, 0);
        check({tag, "_msb_x_valid"}, bus_m.x_valid, 0);
        check({tag, "_msb_last"}, bus_m.last, 0);
        check({tag, "_msb_busy"}, bus_m.busy, 0);
        check({tag, "_msb_din_ready"}, bus_m.din_ready, 1);
        check({tag, "_lsb_x"}, bus_l.x, 0);
        check({tag, "_lsb_x_valid"}, bus_l.x_valid, 0);
        check({tag, "_lsb_busy"}, bus_l.busy, 0);
        check({tag, "_lsb_din_ready"}, bus_l.din_ready, 1);
    endtask

    initial begin
        int drain;
        reset_n   = 1'b0;
        din_valid = 1'b0;
        din       = '0;
        #3;
        check_reset_outputs("reset");
        #9 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle stall: monitor checks quiet outputs every cycle.
        idle(20);

        // Single word, then a word aimed at the LSB-first instance.
        send(8'hB0);
        idle(10);
        send(8'h0D);
        idle(10);

        // Back-to-back with hold full, then a third queued word.
        send(8'hA5);
        send(8'h3C);
        send(8'hFF);
        idle(26);

        // Bypass: offer the next word during the cycle that shows last=1.
        send(8'h96);
        idle(7);
        send(8'h5A);
        idle(12);

        // Reset mid-word with a second word held.
        send(8'hFF);
        send(8'h81);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        q_m.delete();
        q_l.delete();
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #2;
        check_reset_outputs("midreset_hold");
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        idle(6);

        // Randomized traffic with random gaps.
        for (int n = 0; n < 150; n++) begin
            int gap;
            gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 10));
            if (gap > 0) idle(gap);
            send(WIDTH'($urandom));
        end

        drain = 0;
        while ((q_m.size() > 0 || q_l.size() > 0) && drain < 3 * WIDTH + 10) begin
            @(posedge clk);
            drain++;
        end
        #1;
        check("drain_msb_empty", q_m.size(), 0);
        check("drain_lsb_empty", q_l.size(), 0);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial front end for the Mealy overlapping sequence detector.
- Accepts WIDTH-bit words on a valid/ready handshake and emits them one bit per clock on x.
- x connects directly to the detector's serial input; x_valid and last are provided for framing and monitoring.
- One holding register behind the shift register sustains gapless back-to-back words.

Parameters:
- WIDTH, 8, word width in bits (>=2).
- MSB_FIRST, 1, 1 = bit WIDTH-1 is shifted out first; 0 = bit 0 is shifted out first.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  parallel word.
- din_valid  input  1  din holds a valid word.
- din_ready  output  1  block can accept a word this cycle.
- x  output  1  serial bit to the detector.
- x_valid  output  1  x carries a data bit this cycle.
- last  output  1  x is the final bit of the current word.
- busy  output  1  shifter active or holding register full.

Behaviour:
- Single clock; reset is asynchronous and active-low.
- Reset values (all state cleared asynchronously):
  - active=0, hold_full=0, cnt=0, shift and hold registers=0.
  - x=0, x_valid=0, last=0, busy=0, din_ready=1.
- Accept: a word is accepted on any rising edge with din_valid=1 and din_ready=1. din_ready = !hold_full (state only, no combinational path from din_valid).
- State: active flag plus bit counter cnt in 0..WIDTH-1.
- IDLE (active=0):
  - An accepted word loads the shifter directly; active=1, cnt=0.
  - Latency: word accepted at edge N -> first bit on x in the cycle after edge N.
- SHIFT (active=1):
  - x = current bit of the shifter, x_valid=1.
  - Each edge: cnt+1 and shift by one in the configured direction.
- SHIFT with cnt==WIDTH-1 (last=1), next edge:
  - hold_full=1: hold loads the shifter, hold_full=0, cnt=0.
  - Else, word accepted this edge: it bypasses directly into the shifter, cnt=0.
  - Else: active=0.
  - Result: back-to-back words produce a continuous bit stream with zero idle cycles.
- SHIFT with cnt<WIDTH-1, word accepted: it goes to hold, hold_full=1, din_ready=0 from the next cycle.
- IDLE with hold_full=1 cannot occur; the bench asserts this never happens.
- Idle output: x=0, x_valid=0, last=0. The detector sees zeros between words, so no false match can span an idle gap begun with 0.
- Outputs are derived only from registers; no combinational path from din or din_valid to x, x_valid or last.
- busy = active | hold_full.
- Reset mid-word: in-flight and held words are discarded. x drops to 0 immediately (asynchronous), and no partial word resumes after release.
- din is sampled only on accept edges; din changes at other times are ignored.

Test Plan:
- Single word, WIDTH=8, MSB_FIRST=1: din=8'hB0 accepted at edge N -> x=1,0,1,1,0,0,0,0 on cycles N+1..N+8, x_valid=1 throughout, last=1 only on N+8, x_valid=0 at N+9. Detector z pulses on the 4th bit.
- Back-to-back: din_valid held high with 8'hA5 then 8'h3C (then 8'hFF queued) -> 24 contiguous x bits 10100101 00111100 11111111, no gap. din_ready low while hold is full and high again the cycle after hold drains.
- Bypass on last bit: offer a new word exactly on the cycle last=1 with hold empty -> accepted and its bit 0 appears immediately after the previous last bit, hold_full stays 0.
- LSB first: MSB_FIRST=0, din=8'h0D -> x=1,0,1,1,0,0,0,0.
- Reset mid-word: assert reset_n=0 after 3 bits of 8'hFF with a second word held -> x=0, x_valid=0, busy=0, din_ready=1 immediately. After release, x stays 0 until a new word is accepted.
- Idle/stall: din_valid=0 for 20 cycles after reset -> x=0, x_valid=0, last=0, busy=0, din_ready=1 throughout.
